// File: rtl/cola_fifo.sv
// First-word-fall-through FIFO fed by push/pop button regulators.
// Define FIFO_COUNT_EN to add the occupancy output port count.
module cola_fifo #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full
`ifdef FIFO_COUNT_EN
    ,
    output logic [W:0]   count
`endif
);

    logic [B-1:0] mem [2**W];

    logic [W-1:0] w_ptr, w_next, w_succ;
    logic [W-1:0] r_ptr, r_next, r_succ;
    logic         full_reg, full_next;
    logic         empty_reg, empty_next;
    logic         wr_ok, rd_ok;

    // flags are sampled before this edge's ops, so a full
    // FIFO drops a write even when a read frees a slot
    assign wr_ok  = wr & ~full_reg;
    assign rd_ok  = rd & ~empty_reg;
    assign w_succ = w_ptr + 1'b1;
    assign r_succ = r_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[w_ptr] <= w_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            w_ptr     <= w_next;
            r_ptr     <= r_next;
            full_reg  <= full_next;
            empty_reg <= empty_next;
        end
    end

    always_comb begin
        w_next     = w_ptr;
        r_next     = r_ptr;
        full_next  = full_reg;
        empty_next = empty_reg;
        unique case ({wr_ok, rd_ok})
            2'b10: begin
                w_next     = w_succ;
                empty_next = 1'b0;
                full_next  = (w_succ == r_ptr);
            end
            2'b01: begin
                r_next     = r_succ;
                full_next  = 1'b0;
                empty_next = (r_succ == w_ptr);
            end
            2'b11: begin
                w_next = w_succ;
                r_next = r_succ;
            end
            default: ;
        endcase
    end

    assign r_data = mem[r_ptr];
    assign full   = full_reg;
    assign empty  = empty_reg;

`ifdef FIFO_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (wr_ok & ~rd_ok)
            count <= count + 1'b1;
        else if (rd_ok & ~wr_ok)
            count <= count - 1'b1;
    end
`endif

endmodule

// File: tb/tb_cola_fifo.sv
// Directed vector bench for cola_fifo (B=8, W=2).
// Count checks are compiled in when FIFO_COUNT_EN is defined.
module tb_cola_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] w_data = '0;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
`ifdef FIFO_COUNT_EN
    logic [2:0] count;
`endif

    int checks = 0;
    int errors = 0;

    cola_fifo #(.B(8), .W(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .rd     (rd),
        .w_data (w_data),
        .r_data (r_data),
        .empty  (empty),
        .full   (full)
`ifdef FIFO_COUNT_EN
        ,
        .count  (count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] d;
        logic       e;
        logic       f;
        logic       cr;
        logic [7:0] rq;
        logic [2:0] c;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(logic w, logic r, logic [7:0] d,
                                logic e, logic f, logic cr,
                                logic [7:0] rq, logic [2:0] c);
        vec_t x;
        x.w = w; x.r = r; x.d = d; x.e = e;
        x.f = f; x.cr = cr; x.rq = rq; x.c = c;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [2:0] exp);
`ifdef FIFO_COUNT_EN
        chk(nm, {29'd0, count}, {29'd0, exp});
`else
        if (exp === 3'bxxx) $display("count %s", nm);
`endif
    endtask

    task automatic chk_state(input string nm, input logic e,
                             input logic f, input logic [2:0] c);
        chk({nm, ".empty"}, {31'd0, empty}, {31'd0, e});
        chk({nm, ".full"}, {31'd0, full}, {31'd0, f});
        chk({nm, ".excl"}, {31'd0, empty & full}, 32'd0);
        chk_cnt({nm, ".count"}, c);
    endtask

    task automatic step(input logic w, input logic r,
                        input logic [7:0] d);
        @(negedge clk);
        wr = w; rd = r; w_data = d;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    initial begin
        // async reset mid-cycle, checked before any clock edge
        #3 reset = 1'b1;
        #1 chk_state("rst0", 1'b1, 1'b0, 3'd0);
        #1 reset = 1'b0;

        // fill, overflow, drain, underflow, 5C
        v.push_back(mk(1,0,8'hA1, 0,0,1,8'hA1,3'd1));
        v.push_back(mk(1,0,8'hA2, 0,0,1,8'hA1,3'd2));
        v.push_back(mk(1,0,8'hA3, 0,0,1,8'hA1,3'd3));
        v.push_back(mk(1,0,8'hA4, 0,1,1,8'hA1,3'd4));
        v.push_back(mk(1,0,8'hFF, 0,1,1,8'hA1,3'd4));
        v.push_back(mk(0,1,8'h00, 0,0,1,8'hA2,3'd3));
        v.push_back(mk(0,1,8'h00, 0,0,1,8'hA3,3'd2));
        v.push_back(mk(0,1,8'h00, 0,0,1,8'hA4,3'd1));
        v.push_back(mk(0,1,8'h00, 1,0,0,8'h00,3'd0));
        v.push_back(mk(0,1,8'h00, 1,0,0,8'h00,3'd0));
        v.push_back(mk(1,0,8'h5C, 0,0,1,8'h5C,3'd1));
        v.push_back(mk(0,1,8'h00, 1,0,0,8'h00,3'd0));
        // simultaneous: two stored, then empty, then full
        v.push_back(mk(1,0,8'h11, 0,0,1,8'h11,3'd1));
        v.push_back(mk(1,0,8'h22, 0,0,1,8'h11,3'd2));
        v.push_back(mk(1,1,8'h33, 0,0,1,8'h22,3'd2));
        v.push_back(mk(0,1,8'h00, 0,0,1,8'h33,3'd1));
        v.push_back(mk(0,1,8'h00, 1,0,0,8'h00,3'd0));
        v.push_back(mk(1,1,8'h77, 0,0,1,8'h77,3'd1));
        v.push_back(mk(1,0,8'h88, 0,0,1,8'h77,3'd2));
        v.push_back(mk(1,0,8'h99, 0,0,1,8'h77,3'd3));
        v.push_back(mk(1,0,8'hAA, 0,1,1,8'h77,3'd4));
        v.push_back(mk(1,1,8'hBB, 0,0,1,8'h88,3'd3));
        v.push_back(mk(0,1,8'h00, 0,0,1,8'h99,3'd2));
        v.push_back(mk(0,1,8'h00, 0,0,1,8'hAA,3'd1));
        v.push_back(mk(0,1,8'h00, 1,0,0,8'h00,3'd0));

        foreach (v[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            step(v[i].w, v[i].r, v[i].d);
            chk_state(nm, v[i].e, v[i].f, v[i].c);
            if (v[i].cr)
                chk({nm, ".r_data"}, {24'd0, r_data}, {24'd0, v[i].rq});
        end

        // wrap-around: pointers pass the end of the array twice
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            d = 8'(i * 17 + 3);
            step(1'b1, 1'b0, d);
            chk_state($sformatf("wrap%0d.w", i), 1'b0, 1'b0, 3'd1);
            chk($sformatf("wrap%0d.r_data", i), {24'd0, r_data},
                {24'd0, d});
            step(1'b0, 1'b1, 8'h00);
            chk_state($sformatf("wrap%0d.r", i), 1'b1, 1'b0, 3'd0);
        end

        // reset mid-run with 3 words stored
        step(1'b1, 1'b0, 8'hC1);
        step(1'b1, 1'b0, 8'hC2);
        step(1'b1, 1'b0, 8'hC3);
        chk_state("pre_rst", 1'b0, 1'b0, 3'd3);
        chk("pre_rst.r_data", {24'd0, r_data}, 32'hC1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk_state("rst1", 1'b1, 1'b0, 3'd0);
        #1 reset = 1'b0;
        step(1'b1, 1'b0, 8'hD4);
        chk_state("post_rst", 1'b0, 1'b0, 3'd1);
        chk("post_rst.r_data", {24'd0, r_data}, 32'hD4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/cola_fifo.md
Name: cola_fifo

Overview:
- Small synchronous FIFO queue placed directly downstream of the push-button regulators.
- Its write and read strobes are the single-cycle pulses produced by two button_regulator instances (push button, pop button).
- Write data comes from board switches; read data and the status flags drive LEDs.
- Data is first-word-fall-through: the head of the queue is always visible on r_data.

Parameters:
- B, 8, data word width in bits.
- W, 2, address width in bits; depth = 2^W words (default 4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  write strobe; one-cycle pulse from the push-button regulator.
- rd  input  1  read/pop strobe; one-cycle pulse from the pop-button regulator.
- w_data  input  B  word to enqueue, sampled on a clk edge where the write is accepted.
- r_data  output  B  word at the head of the queue, read combinationally as mem[r_ptr].
- empty  output  1  queue holds 0 words.
- full  output  1  queue holds 2^W words.

Behaviour:
- Storage and state:
  - Memory array of 2^W x B bits; the array itself is not reset.
  - W-bit write pointer w_ptr and W-bit read pointer r_ptr.
  - Registered flags full_reg and empty_reg.
- Reset (asynchronous, any time, including mid-operation):
  - w_ptr=0, r_ptr=0, full=0, empty=1.
  - r_data is don't-care after reset; the memory contents are not cleared.
- Accepted operations, evaluated on each rising clk edge using the current flags:
  - Write accepted = wr & ~full.
  - Read accepted = rd & ~empty.
- {wr,rd}=00: no change.
- {wr,rd}=10, not full:
  - mem[w_ptr] <= w_data; w_ptr <= w_ptr+1.
  - empty <= 0.
  - full <= (w_ptr+1 == r_ptr).
- {wr,rd}=10, full: write ignored, no state change.
- {wr,rd}=01, not empty:
  - r_ptr <= r_ptr+1.
  - full <= 0.
  - empty <= (r_ptr+1 == w_ptr).
- {wr,rd}=01, empty: read ignored, no state change.
- {wr,rd}=11, neither empty nor full: write and read both occur; both pointers advance; flags unchanged.
- {wr,rd}=11, empty: only the write occurs; empty <= 0; r_ptr holds.
- {wr,rd}=11, full: only the read occurs; the write is dropped because full is evaluated before the read frees a slot; full <= 0.
- Pointer arithmetic is modulo 2^W; wrap-around from 2^W-1 to 0 is silent.
- Flag timing:
  - Flags update on the same edge that changes the pointers.
  - r_data reflects a new head combinationally, in the same cycle the pointer changes.
  - Write-to-visible latency on an empty FIFO is 1 clk: data appears on r_data the cycle after the wr edge.
- Input requirements: wr and rd must be synchronous one-cycle pulses. A held level means one operation per clk cycle; the block does not edge-detect its inputs.
- full and empty are never both 1.

Optional Feature:
- Macro: FIFO_COUNT_EN.
- Defined:
  - Adds output port count [W:0], the occupancy 0..2^W.
  - count resets to 0.
  - count increments on an accepted write-only cycle, decrements on an accepted read-only cycle, and holds on an accepted simultaneous write+read.
  - count must always equal the number of stored words, consistent with the flags: empty iff count==0, full iff count==2^W.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: assert reset for 1 cycle mid-clock -> empty=1, full=0 immediately (asynchronous); count=0 if enabled.
- Fill (defaults B=8, W=2): write 8'hA1, A2, A3, A4 on consecutive cycles -> empty=0 after the first edge; full=1 after the 4th; r_data=8'hA1 throughout.
- Overflow: with the FIFO full, pulse wr with 8'hFF -> no change. Then pop 4 times -> r_data sequence A1, A2, A3, A4; empty=1 after the 4th pop; 8'hFF never appears.
- Underflow: with the FIFO empty, pulse rd -> pointers unchanged, empty stays 1. Then write 8'h5C -> r_data=8'h5C next cycle.
- Simultaneous operations:
  - With 2 words stored (11, 22), wr=rd=1 with 8'h33 -> r_data=22, flags unchanged, count stays 2.
  - On empty, wr=rd=1 with 8'h77 -> r_data=77, empty=0.
  - On full, wr=rd=1 -> one word popped, incoming write dropped, full=0.
- Wrap-around and reset mid-run: perform 10 alternating write/read pairs so both pointers wrap twice -> each read returns the word just written. Then assert reset with 3 words stored -> empty=1, and a subsequent write is read back first.
